dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/mips_pkg.sv | 20 ++
 rtl/dmem_array.sv | 25 ++
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default
// parameter values and the address legality check.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int DEFAULT_DEPTH_WORDS = 1024;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    // Misaligned or beyond the last implemented word.
    function automatic logic addr_err(input logic [31:0] ad, input int depth);
        return (ad[1:0] != 2'b00) || ({2'b00, ad[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: one synchronous write port, one asynchronous read
// port. Contents are not reset here; the responder clears them by sweeping.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          Clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge Clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: clears its storage after reset, then serves one
// load/store at a time with a fixed number of wait states before the response.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is high only in IDLE. resp_valid is a single
// cycle strobe and qualifies DM and resp_err; there is no response back-pressure.
module dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] Ad,
    input  logic [31:0] WrData,
    output logic        resp_valid,
    output logic [31:0] DM,
    output logic        resp_err,
    output state_t      o_dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_clr_cnt;
    logic [3:0]    r_wait_cnt;
    logic          r_wr;
    logic [31:0]   r_ad;
    logic [31:0]   r_wdata;

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_cmd_wr;
    logic [31:0]   w_cmd_ad;
    logic [31:0]   w_cmd_data;
    logic          w_commit;
    logic          w_clear_we;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rdata;
    logic          w_rd_err;

    assign w_accept = (r_state == ST_IDLE) && req_valid;

    // With zero wait states the commit edge is the acceptance edge itself, so
    // the command must come straight from the inputs rather than the latches.
    assign w_cmd_wr   = (r_state == ST_IDLE) ? req_wr : r_wr;
    assign w_cmd_ad   = (r_state == ST_IDLE) ? Ad     : r_ad;
    assign w_cmd_data = (r_state == ST_IDLE) ? WrData : r_wdata;

    assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                          ((r_state == ST_WAIT) && (r_wait_cnt <= 4'd1));

    assign w_commit   = w_enter_resp && w_cmd_wr && !addr_err(w_cmd_ad, DEPTH_WORDS) && !Reset;
    assign w_clear_we = (r_state == ST_CLEAR) && !Reset;

    assign w_we    = w_clear_we || w_commit;
    assign w_waddr = w_clear_we ? r_clr_cnt : w_cmd_ad[AW+1:2];
    assign w_wdata = w_clear_we ? 32'h0 : w_cmd_data;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .Clk     (Clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_ad[AW+1:2]),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == AW'(DEPTH_WORDS - 1)) w_next = ST_IDLE;
            ST_IDLE:  if (req_valid) w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (r_wait_cnt <= 4'd1) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_CLEAR;
            r_clr_cnt  <= '0;
            r_wait_cnt <= 4'd0;
            r_wr       <= 1'b0;
            r_ad       <= 32'h0;
            r_wdata    <= 32'h0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if (w_accept) begin
                r_wr       <= req_wr;
                r_ad       <= Ad;
                r_wdata    <= WrData;
                r_wait_cnt <= 4'(WAIT_CYCLES);
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    assign w_rd_err    = addr_err(r_ad, DEPTH_WORDS);
    assign req_ready   = (r_state == ST_IDLE) && !Reset;
    assign resp_valid  = (r_state == ST_RESP) && !Reset;
    assign resp_err    = resp_valid && w_rd_err;
    assign DM          = (resp_valid && !r_wr && !w_rd_err) ? w_rdata : 32'h0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 1024-word, 2-wait-state instance and a
// 16-word, zero-wait-state instance sharing clock, reset and request fields.
module tb_dmem_responder;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        valid0, valid1;
    logic        wr;
    logic [31:0] ad, wdata;

    logic        ready0, rv0, err0;
    logic [31:0] dm0;
    state_t      st0;
    logic        ready1, rv1, err1;
    logic [31:0] dm1;
    state_t      st1;

    int          cyc;
    int          checks;
    int          errors;
    logic [32:0] exp_q[$];
    int          acc_log[$];
    bit          mon_en;
    int          rv_cnt;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut0 (
        .Clk(clk), .Reset(reset), .req_valid(valid0), .req_ready(ready0),
        .req_wr(wr), .Ad(ad), .WrData(wdata), .resp_valid(rv0), .DM(dm0),
        .resp_err(err0), .o_dbg_state(st0)
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut1 (
        .Clk(clk), .Reset(reset), .req_valid(valid1), .req_ready(ready1),
        .req_wr(wr), .Ad(ad), .WrData(wdata), .resp_valid(rv1), .DM(dm1),
        .resp_err(err1), .o_dbg_state(st1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mon_en) begin
            if (valid0 && ready0) acc_log.push_back(cyc);
            if (rv0) rv_cnt++;
        end
    end

    function automatic logic sel_ready(input int sel);
        return (sel != 0) ? ready1 : ready0;
    endfunction

    function automatic logic sel_rv(input int sel);
        return (sel != 0) ? rv1 : rv0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int sel, input int budget, output int n);
        n = 0;
        while (!sel_ready(sel) && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // driver: issue one request, push its expectation, then check the response
    task automatic do_req(input string tag, input int sel, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_dm, input logic exp_err,
                          input int exp_lat);
        int n;
        int acc;
        logic [32:0] e;
        wait_ready(sel, 2000, n);
        chk({tag, " ready"}, 32'(sel_ready(sel)), 32'd1);
        wr = w; ad = a; wdata = d;
        if (sel != 0) valid1 = 1'b1; else valid0 = 1'b1;
        acc = cyc;
        exp_q.push_back({exp_err, exp_dm});
        @(negedge clk);
        valid0 = 1'b0; valid1 = 1'b0;
        wr = $urandom_range(0, 1); ad = $urandom; wdata = $urandom;
        n = 0;
        while (!sel_rv(sel) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(cyc - acc), 32'(exp_lat));
        e = exp_q.pop_front();
        chk({tag, " dm"}, (sel != 0) ? dm1 : dm0, e[31:0]);
        chk({tag, " err"}, 32'((sel != 0) ? err1 : err0), 32'(e[32]));
        @(negedge clk);
        chk({tag, " strobe width"}, 32'(sel_rv(sel)), 32'd0);
        chk({tag, " ready after resp"}, 32'(sel_ready(sel)), 32'd1);
    endtask

    initial begin
        int n;
        int n1;
        checks = 0; errors = 0; mon_en = 0; rv_cnt = 0;
        reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
        wr = 1'b0; ad = 32'h0; wdata = 32'h0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst ready", 32'(ready0), 32'd0);
        chk("rst resp_valid", 32'(rv0), 32'd0);
        chk("rst dm", dm0, 32'h0);
        chk("rst err", 32'(err0), 32'd0);
        chk("rst state", 32'(st0), 32'(ST_CLEAR));

        // clear sweep length, with req_valid pestering during CLEAR
        reset = 1'b0;
        valid0 = 1'b1;
        n = 0; n1 = -1;
        while (!ready0 && n < 3000) begin
            if (ready1 && n1 < 0) n1 = n;
            @(negedge clk);
            n++;
        end
        valid0 = 1'b0;
        chk("clear cycles dut0", 32'(n), 32'd1024);
        chk("clear cycles dut1", 32'(n1), 32'd16);

        do_req("load top", 0, 1'b0, 32'h0000_0FFC, 32'h0, 32'h0, 1'b0, 3);
        do_req("store 10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3);
        do_req("load 10", 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        do_req("store misaligned", 0, 1'b1, 32'h13, 32'h1111_1111, 32'h0, 1'b1, 3);
        do_req("store oor", 0, 1'b1, 32'h1000, 32'h2222_2222, 32'h0, 1'b1, 3);
        do_req("load misaligned", 0, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 3);
        do_req("reload 10", 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        do_req("reload 0", 0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 3);

        // req_valid held high: acceptances every WAIT_CYCLES+2 cycles
        wait_ready(0, 100, n);
        acc_log.delete();
        rv_cnt = 0; mon_en = 1;
        wr = 1'b0; ad = 32'h10; valid0 = 1'b1;
        repeat (13) @(negedge clk);
        valid0 = 1'b0;
        repeat (6) @(negedge clk);
        mon_en = 0;
        chk("stream accepts", 32'(acc_log.size()), 32'd4);
        for (int i = 1; i < acc_log.size(); i++) begin
            chk("stream spacing", 32'(acc_log[i] - acc_log[i-1]), 32'd4);
        end
        chk("stream responses", 32'(rv_cnt), 32'd4);

        // reset in the first WAIT cycle aborts a store
        wait_ready(0, 100, n);
        wr = 1'b1; ad = 32'h20; wdata = 32'h12345678; valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        chk("abort in wait", 32'(st0), 32'(ST_WAIT));
        rv_cnt = 0; mon_en = 1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        mon_en = 0;
        chk("abort no resp", 32'(rv_cnt), 32'd0);
        chk("abort state", 32'(st0), 32'(ST_CLEAR));
        do_req("load 20 after abort", 0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 3);

        // zero wait states, 16-word instance
        do_req("w0 store last", 1, 1'b1, 32'h3C, 32'hCAFEF00D, 32'h0, 1'b0, 1);
        do_req("w0 load last", 1, 1'b0, 32'h3C, 32'h0, 32'hCAFEF00D, 1'b0, 1);
        do_req("w0 store oor", 1, 1'b1, 32'h40, 32'h5555_AAAA, 32'h0, 1'b1, 1);
        do_req("w0 load 0", 1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1);
        do_req("w0 store 4", 1, 1'b1, 32'h4, 32'h0BAD_F00D, 32'h0, 1'b0, 1);
        do_req("w0 load 4", 1, 1'b0, 32'h4, 32'h0, 32'h0BAD_F00D, 1'b0, 1);

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
